correlator_dwell_scheduler: RTL

// - Sequences the 200 Mchip/s correlator through a programmable list of dwells.
// - Each dwell entry is {code_type, seed, code_len, threshold}.
// - Per dwell: loads the correlator config, pulses clear, enables integration,

---
 rtl/correlator_dwell_scheduler.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/correlator_dwell_scheduler.sv
// ============================================================================
// Module   : correlator_dwell_scheduler
// Brief    : Steps the correlator through a programmable dwell table and emits
//            one result record per dwell. Optional macro: SCHED_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module correlator_dwell_scheduler #(
    parameter int  MAX_DWELLS = 8,
    parameter int  SETTLE_CYC = 4,
    parameter int  TIMEOUT_W  = 24,
    parameter int  MAG_W      = 32,
    localparam int ADDR_W     = $clog2(MAX_DWELLS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W:0]       cfg_num_dwells,
    input  logic [TIMEOUT_W-1:0]  cfg_timeout,
    input  logic                  tbl_wr_en,
    input  logic [ADDR_W-1:0]     tbl_wr_addr,
    input  logic [69:0]           tbl_wr_data,
    output logic                  corr_enable,
    output logic                  corr_clear,
    output logic [1:0]            corr_code_type,
    output logic [19:0]           corr_seed,
    output logic [15:0]           corr_code_len,
    output logic [MAG_W-1:0]      corr_threshold,
    input  logic                  corr_int_done,
    input  logic                  corr_det_valid,
    input  logic [MAG_W-1:0]      corr_peak_mag,
    input  logic [15:0]           corr_peak_phase,
    output logic [MAG_W+15:0]     res_tdata,
    output logic [ADDR_W+1:0]     res_tuser,
    output logic                  res_tvalid,
    input  logic                  res_tready,
    output logic                  busy,
    output logic                  list_done,
    output logic                  timeout_err
);

`ifdef SCHED_REPEAT_EN
    localparam bit c_repeat = 1'b1;
`else
    localparam bit c_repeat = 1'b0;
`endif

    localparam int              c_set_w       = $clog2(SETTLE_CYC + 1);
    localparam logic [c_set_w-1:0] c_settle_last = c_set_w'(SETTLE_CYC - 1);
    localparam logic [ADDR_W:0]    c_max_num     = (ADDR_W + 1)'(MAX_DWELLS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_RUN     = 3'd3,
        S_CAPTURE = 3'd4,
        S_EMIT    = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [69:0]            r_table [MAX_DWELLS];
    logic [ADDR_W-1:0]      r_idx;
    logic [ADDR_W:0]        r_num;
    logic [c_set_w-1:0]     r_settle;
    logic [TIMEOUT_W-1:0]   r_cnt;
    logic                   r_to_flag;
    logic                   r_timeout_err;
    logic                   r_list_done;
    logic [1:0]             r_cfg_type;
    logic [19:0]            r_cfg_seed;
    logic [15:0]            r_cfg_len;
    logic [MAG_W-1:0]       r_cfg_thr;
    logic [MAG_W-1:0]       r_res_mag;
    logic [15:0]            r_res_phase;
    logic                   r_res_det;
    logic                   r_res_to;

    logic                   w_last;
    logic [TIMEOUT_W-1:0]   w_cnt_next;
    logic                   w_timeout_hit;
    logic                   w_to_now;
    logic [ADDR_W:0]        w_num_clamped;
    logic [ADDR_W-1:0]      w_load_idx;
    logic [69:0]            w_entry;

    assign w_last        = ({1'b0, r_idx} == (r_num - 1'b1));
    assign w_cnt_next    = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_timeout_hit = (cfg_timeout != '0) && (w_cnt_next == cfg_timeout);
    assign w_to_now      = w_timeout_hit && !corr_int_done;
    assign w_num_clamped = (cfg_num_dwells > c_max_num) ? c_max_num : cfg_num_dwells;
    // Next dwell to load: 0 on a fresh list or a wrap, else the following entry
    assign w_load_idx    = (r_state == S_EMIT && !w_last) ? r_idx + 1'b1 : '0;
    assign w_entry       = r_table[w_load_idx];

    always_ff @(posedge clk) begin
        if (tbl_wr_en) begin
            r_table[tbl_wr_addr] <= tbl_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (start && cfg_num_dwells != '0) w_state_next = S_LOAD;
                S_LOAD:    w_state_next = S_SETTLE;
                S_SETTLE:  if (r_settle == c_settle_last) w_state_next = S_RUN;
                S_RUN:     if (corr_int_done || w_timeout_hit) w_state_next = S_CAPTURE;
                S_CAPTURE: w_state_next = S_EMIT;
                S_EMIT:    if (res_tready) w_state_next = (w_last && !c_repeat) ? S_IDLE : S_LOAD;
                default:   w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= '0;
            r_num         <= '0;
            r_settle      <= '0;
            r_cnt         <= '0;
            r_to_flag     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_list_done   <= 1'b0;
            r_cfg_type    <= '0;
            r_cfg_seed    <= '0;
            r_cfg_len     <= '0;
            r_cfg_thr     <= '0;
            r_res_mag     <= '0;
            r_res_phase   <= '0;
            r_res_det     <= 1'b0;
            r_res_to      <= 1'b0;
        end else begin
            r_list_done <= 1'b0;
            if (!abort) begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_timeout_err <= 1'b0;
                            if (cfg_num_dwells == '0) begin
                                r_list_done <= 1'b1;
                            end else begin
                                r_num      <= w_num_clamped;
                                r_idx      <= '0;
                                r_cfg_type <= w_entry[69:68];
                                r_cfg_seed <= w_entry[67:48];
                                r_cfg_len  <= w_entry[47:32];
                                r_cfg_thr  <= MAG_W'(w_entry[31:0]);
                            end
                        end
                    end
                    S_LOAD: r_settle <= '0;
                    S_SETTLE: begin
                        r_settle <= r_settle + 1'b1;
                        r_cnt    <= '0;
                    end
                    S_RUN: begin
                        r_cnt     <= w_cnt_next;
                        r_to_flag <= w_to_now;
                        if (w_to_now) r_timeout_err <= 1'b1;
                    end
                    S_CAPTURE: begin
                        r_res_mag   <= corr_peak_mag;
                        r_res_phase <= corr_peak_phase;
                        r_res_det   <= corr_det_valid;
                        r_res_to    <= r_to_flag;
                    end
                    S_EMIT: begin
                        if (res_tready) begin
                            if (w_last) r_list_done <= 1'b1;
                            if (!w_last || c_repeat) begin
                                r_idx      <= w_load_idx;
                                r_cfg_type <= w_entry[69:68];
                                r_cfg_seed <= w_entry[67:48];
                                r_cfg_len  <= w_entry[47:32];
                                r_cfg_thr  <= MAG_W'(w_entry[31:0]);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy           = (r_state != S_IDLE);
    assign corr_enable    = (r_state == S_RUN);
    assign corr_clear     = (r_state == S_LOAD);
    assign res_tvalid     = (r_state == S_EMIT);
    assign corr_code_type = r_cfg_type;
    assign corr_seed      = r_cfg_seed;
    assign corr_code_len  = r_cfg_len;
    assign corr_threshold = r_cfg_thr;
    assign res_tdata      = {r_res_phase, r_res_mag};
    assign res_tuser      = {r_res_to, r_res_det, r_idx};
    assign list_done      = r_list_done;
    assign timeout_err    = r_timeout_err;

endmodule

`default_nettype wire
